// File: rtl/sprite_address_gen.sv
// sprite_address_gen: per-slot sprite-ROM address generator with IDLE/ACTIVE/DONE burst FSM.
// Optional SPRITE_FLIP_EN macro enables horizontal/vertical texel flipping from descriptor bits [30:29].
module sprite_address_gen #(
    parameter int SIZE_X   = 10,
    parameter int SIZE_Y   = 10,
    parameter int SPRITE_W = 20,
    parameter int SPRITE_H = 20,
    parameter int ADDR_W   = 14
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [SIZE_X-1:0] pixel_x,
    input  logic [SIZE_Y-1:0] pixel_y,
    input  logic [31:0]       sprite_datas,
    input  logic              sprite_on,
    output logic [ADDR_W-1:0] memory_address,
    output logic              address_valid,
    output logic              counter_finished
);
    localparam logic [ADDR_W-1:0] ADDRESS_BG = '1;
    localparam int CW = $clog2(SPRITE_W + 1);
`ifdef SPRITE_FLIP_EN
    localparam int DW = 31;
`else
    localparam int DW = 29;
`endif
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] counter, counter_nx;
    logic [DW-1:0] desc, desc_nx;
    logic [ADDR_W-1:0] addr_nx, texel;
    logic valid_nx, fin_nx, hit;
    logic [10:0] px, py, x0, y0, col, row;
    // Bounds are evaluated at 11 bits so x+W / y+H never wrap at the screen edge.
    assign px = 11'(pixel_x);
    assign py = 11'(pixel_y);
    assign x0 = {1'b0, desc[28:19]};
    assign y0 = {1'b0, desc[18:9]};
    assign hit = (px >= x0) && (px < x0 + 11'(SPRITE_W)) && (py >= y0) && (py < y0 + 11'(SPRITE_H));
`ifdef SPRITE_FLIP_EN
    assign col = desc[29] ? 11'(SPRITE_W - 1) - (px - x0) : px - x0;
    assign row = desc[30] ? 11'(SPRITE_H - 1) - (py - y0) : py - y0;
`else
    assign col = px - x0;
    assign row = py - y0;
`endif
    assign texel = ADDR_W'(desc[8:0]) * ADDR_W'(SPRITE_W * SPRITE_H)
                 + ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        desc_nx    = desc;
        addr_nx    = ADDRESS_BG;
        valid_nx   = 1'b0;
        fin_nx     = 1'b0;
        case (state)
            IDLE: if (sprite_on && sprite_datas[31]) begin
                desc_nx    = sprite_datas[DW-1:0];
                counter_nx = '0;
                state_nx   = ACTIVE;
            end
            ACTIVE: if (!sprite_on) begin
                counter_nx = '0;
                state_nx   = IDLE;
            end else begin
                addr_nx    = hit ? texel : ADDRESS_BG;
                valid_nx   = hit;
                counter_nx = counter + CW'(1);
                state_nx   = (counter == CW'(SPRITE_W - 1)) ? DONE : ACTIVE;
            end
            DONE: begin
                fin_nx   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Registers update on the falling edge so the ROM can sample on the rising edge.
    always_ff @(negedge clk_pixel) begin
        if (reset) begin
            state            <= IDLE;
            counter          <= '0;
            desc             <= '0;
            memory_address   <= ADDRESS_BG;
            address_valid    <= 1'b0;
            counter_finished <= 1'b0;
        end else begin
            state            <= state_nx;
            counter          <= counter_nx;
            desc             <= desc_nx;
            memory_address   <= addr_nx;
            address_valid    <= valid_nx;
            counter_finished <= fin_nx;
        end
    end
endmodule
